bus_txn_controller: RTL and testbench

- Control-node initiator (ID 2'b11) for the shared 8-bit tri-state crypto data bus.
- Accepts one transaction request at a time (source ID, destination ID, opcode, byte count) and broadcasts the header byte.
- Releases the bus for the source-node handoff window, then counts data bytes and pulses `ack` to close the transfer and free every node.
- Sits beside the per-module bus nodes, on the control module's side of the bus.

---
 rtl/bus_txn_controller.sv | 189 ++++++++++++++++++
 tb/tb_bus_txn_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_txn_controller.sv
// rtl/bus_txn_controller.sv - control-node initiator for the shared 8-bit crypto data bus
//
// Purpose: accepts one transaction request at a time, broadcasts the header
// byte {2'b00, dest, src, op}, releases the bus for the source-node handoff
// window, counts data bytes and closes the transfer with a one-cycle ack.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_src, req_dest, req_op request source ID, destination ID, opcode
//   req_len                   number of data bytes following the header
//   bus_data, bus_valid       shared tri-state bus; driven only for the header byte
//   ack                       end-of-transfer pulse to every bus node
//   busy                      high whenever not idle
//   done_valid, done_err      completion strobe and its error qualifier
//   done_count                data bytes counted in the finished transaction
//
// Optional feature: define CTRL_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES consecutive cycles without a data byte.
module bus_txn_controller #(
    parameter int LEN_W          = 8,
    parameter int HANDOFF_CYCLES = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_src,
    input  logic [1:0]       req_dest,
    input  logic [1:0]       req_op,
    input  logic [LEN_W-1:0] req_len,
    inout  wire  [7:0]       bus_data,
    inout  wire              bus_valid,
    output logic             ack,
    output logic             busy,
    output logic             done_valid,
    output logic             done_err,
    output logic [LEN_W-1:0] done_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_HANDOFF,
        S_XFER,
        S_ACK
    } state_t;

    localparam int HS_W = (HANDOFF_CYCLES > 1) ? $clog2(HANDOFF_CYCLES) : 1;

    state_t            state;
    logic [7:0]        header_q;
    logic              drive_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  cnt_inc;
    logic [HS_W-1:0]   hs_cnt;
    logic              byte_seen;
    logic              illegal_req;

`ifdef CTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q;
`endif

    // Only a solid 1 on bus_valid is a byte; a floating or unknown line is not.
    assign byte_seen   = (bus_valid == 1'b1);
    assign cnt_inc     = cnt_q + 1'b1;
    assign illegal_req = (req_src == 2'b11) || (req_src == req_dest);

    // drive_q is a register cleared asynchronously, so reset releases the bus at once.
    assign bus_data  = drive_q ? header_q : 8'bz;
    assign bus_valid = drive_q ? 1'b1 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            ack        <= 1'b0;
            busy       <= 1'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            done_count <= '0;
            header_q   <= '0;
            drive_q    <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            hs_cnt     <= '0;
`ifdef CTRL_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            // Strobes and the bus drive last exactly one cycle.
            ack        <= 1'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            drive_q    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        len_q     <= req_len;
                        header_q  <= {2'b00, req_dest, req_src, req_op};
                        cnt_q     <= '0;
                        hs_cnt    <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (illegal_req) begin
                            // Close immediately without ever touching the bus.
                            state      <= S_ACK;
                            ack        <= 1'b1;
                            done_valid <= 1'b1;
                            done_err   <= 1'b1;
                            done_count <= '0;
                        end else begin
                            state   <= S_HEADER;
                            drive_q <= 1'b1;
                        end
                    end
                end

                S_HEADER: begin
                    state <= S_HANDOFF;
                end

                S_HANDOFF: begin
                    // Bus belongs to nobody here; stray valids are ignored.
                    if (hs_cnt == HS_W'(HANDOFF_CYCLES - 1)) begin
                        if (len_q == '0) begin
                            state      <= S_ACK;
                            ack        <= 1'b1;
                            done_valid <= 1'b1;
                            done_count <= '0;
                        end else begin
                            state  <= S_XFER;
`ifdef CTRL_TIMEOUT_EN
                            idle_q <= '0;
`endif
                        end
                    end else begin
                        hs_cnt <= hs_cnt + 1'b1;
                    end
                end

                S_XFER: begin
                    if (byte_seen) begin
                        cnt_q <= cnt_inc;
`ifdef CTRL_TIMEOUT_EN
                        idle_q <= '0;
`endif
                        // Leaving on the final byte is what makes the count saturate.
                        if (cnt_inc == len_q) begin
                            state      <= S_ACK;
                            ack        <= 1'b1;
                            done_valid <= 1'b1;
                            done_count <= cnt_inc;
                        end
                    end
`ifdef CTRL_TIMEOUT_EN
                    else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        state      <= S_ACK;
                        ack        <= 1'b1;
                        done_valid <= 1'b1;
                        done_err   <= 1'b1;
                        done_count <= cnt_q;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
`endif
                end

                S_ACK: begin
                    // No accept here: req_ready only rises with the return to IDLE.
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_txn_controller.sv
// tb/tb_bus_txn_controller.sv - self-checking bench for bus_txn_controller
module tb_bus_txn_controller;

    localparam int LEN_W  = 8;
    localparam int HS     = 3;
    localparam int TMO    = 8;
    localparam int MAXOFF = 64;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       ack;
        logic       dv;
        logic       err;
        logic [7:0] cnt;
        logic       drive;
        logic [7:0] hdr;
        logic       pulse;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_src = 2'd0;
    logic [1:0]       req_dest = 2'd0;
    logic [1:0]       req_op = 2'd0;
    logic [LEN_W-1:0] req_len = '0;
    wire  [7:0]       bus_data;
    wire              bus_valid;
    logic             tb_bv_en = 1'b0;
    logic             ack;
    logic             busy;
    logic             done_valid;
    logic             done_err;
    logic [LEN_W-1:0] done_count;

    assign bus_valid = tb_bv_en ? 1'b1 : 1'bz;

    bus_txn_controller #(
        .LEN_W(LEN_W),
        .HANDOFF_CYCLES(HS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_src(req_src),
        .req_dest(req_dest),
        .req_op(req_op),
        .req_len(req_len),
        .bus_data(bus_data),
        .bus_valid(bus_valid),
        .ack(ack),
        .busy(busy),
        .done_valid(done_valid),
        .done_err(done_err),
        .done_count(done_count)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    exp_t       e;
    logic       exp_en = 1'b0;
    int         cur_off = -1;
    logic [7:0] cur_hdr = 8'h00;
    bit         sched [0:MAXOFF-1];
    int         last_ack_off;
    int         last_cnt;
    int         last_err;
    logic [7:0] hdr_seen;
    logic [1:0] nxt_src, nxt_dest, nxt_op;
    int         nxt_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (offset %0d)", name, act, expv, cur_off);
        end
    endtask

    // Compare process: DUT outputs against the per-cycle model expectation.
    always @(negedge clk) begin
        if (exp_en) begin
            check("req_ready", 32'(req_ready), 32'(e.ready));
            check("busy", 32'(busy), 32'(e.busy));
            check("ack", 32'(ack), 32'(e.ack));
            check("done_valid", 32'(done_valid), 32'(e.dv));
            if (e.dv) begin
                check("done_err", 32'(done_err), 32'(e.err));
                check("done_count", 32'(done_count), 32'(e.cnt));
            end
            if (e.drive) begin
                check("header_valid", 32'(bus_valid === 1'b1), 32'd1);
                check("header_data", 32'(bus_data), 32'(e.hdr));
            end else begin
                if (!e.pulse) check("bus_valid_released", 32'(bus_valid === 1'b1), 32'd0);
                if (e.hdr != 8'h00) check("bus_data_released", 32'(bus_data === e.hdr), 32'd0);
            end
            if (ack === 1'b1) begin
                last_ack_off = cur_off;
                last_cnt     = int'(done_count);
                last_err     = int'(done_err);
            end
            if (cur_off == 1 && bus_valid === 1'b1) hdr_seen = bus_data;
        end
    end

    function automatic exp_t idle_exp();
        exp_t x;
        x       = '0;
        x.ready = 1'b1;
        x.hdr   = cur_hdr;
        return x;
    endfunction

    // Transaction-level model: when does ack land and with what result.
    function automatic void model(input logic [1:0] s, input logic [1:0] d, input int len,
                                  output int ack_off, output bit err, output int cnt);
        int idle;
        err = 1'b0;
        cnt = 0;
        idle = 0;
        ack_off = -1;
        if (s == 2'd3 || s == d) begin
            ack_off = 1;
            err = 1'b1;
            return;
        end
        if (len == 0) begin
            ack_off = 2 + HS;
            return;
        end
        for (int t = 2 + HS; t < MAXOFF; t++) begin
            if (sched[t]) begin
                cnt++;
                idle = 0;
                if (cnt == len) begin
                    ack_off = t + 1;
                    return;
                end
            end else begin
`ifdef CTRL_TIMEOUT_EN
                idle++;
                if (idle == TMO) begin
                    ack_off = t + 1;
                    err = 1'b1;
                    return;
                end
`endif
            end
        end
    endfunction

    task automatic drive_cycle(input logic rv, input logic [1:0] s, input logic [1:0] d,
                               input logic [1:0] o, input int l, input logic pulse,
                               input exp_t ex, input int off);
        @(posedge clk);
        #1;
        req_valid = rv;
        req_src   = s;
        req_dest  = d;
        req_op    = o;
        req_len   = LEN_W'(l);
        tb_bv_en  = pulse;
        e         = ex;
        exp_en    = 1'b1;
        cur_off   = off;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, req_src, req_dest, req_op, int'(req_len), 1'b0, idle_exp(), -1);
    endtask

    task automatic run_txn(input logic [1:0] s, input logic [1:0] d, input logic [1:0] o,
                           input int len, input bit b2b, input int max_off);
        int   ack_off, cnt, last;
        bit   err;
        exp_t x;
        model(s, d, len, ack_off, err, cnt);
        cur_hdr = {2'b00, d, s, o};
        last = (ack_off < 0 || ack_off > max_off) ? max_off : ack_off;
        for (int t = 0; t <= last; t++) begin
            x       = '0;
            x.hdr   = cur_hdr;
            x.ready = (t == 0);
            x.busy  = (t != 0);
            if (t == ack_off) begin
                x.ack = 1'b1;
                x.dv  = 1'b1;
                x.err = err;
                x.cnt = 8'(cnt);
            end
            x.drive = (t == 1) && !err;
            x.pulse = (t >= 2) && sched[t];
            if (t == 0)
                drive_cycle(1'b1, s, d, o, len, x.pulse, x, t);
            else if (t == ack_off && b2b)
                drive_cycle(1'b1, nxt_src, nxt_dest, nxt_op, nxt_len, x.pulse, x, t);
            else
                drive_cycle(1'b0, s, d, o, len, x.pulse, x, t);
        end
    endtask

    task automatic clear_sched();
        for (int t = 0; t < MAXOFF; t++) sched[t] = 1'b0;
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        tb_bv_en  = 1'b0;
        cur_off   = -1;
        e         = idle_exp();
        #1;
        check("rst_bus_valid", 32'(bus_valid === 1'b1), 32'd0);
        check("rst_bus_data", 32'(bus_data === cur_hdr), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        logic [1:0] s, d, o;
        int         l;
        bit         b2b;

        clear_sched();
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);

        // Nominal: 1 -> 2, four bytes at cycles 5..8.
        clear_sched();
        for (int t = 5; t <= 8; t++) sched[t] = 1'b1;
        last_ack_off = -1; hdr_seen = 8'h00;
        run_txn(2'd1, 2'd2, 2'd0, 4, 1'b0, MAXOFF - 1);
        idle_cycles(2);
        check("pin_nominal_header", 32'(hdr_seen), 32'h24);
        check("pin_nominal_ack_cycle", 32'(last_ack_off), 32'd9);
        check("pin_nominal_count", 32'(last_cnt), 32'd4);

        // Gapped data with stray pulses in the handoff window.
        clear_sched();
        sched[2] = 1'b1; sched[3] = 1'b1; sched[4] = 1'b1;
        sched[5] = 1'b1; sched[9] = 1'b1; sched[12] = 1'b1;
        last_ack_off = -1;
        run_txn(2'd2, 2'd0, 2'd3, 3, 1'b0, MAXOFF - 1);
        idle_cycles(1);
        check("pin_gapped_ack_cycle", 32'(last_ack_off), 32'd13);
        check("pin_gapped_count", 32'(last_cnt), 32'd3);

        // Illegal request: no header, immediate error ack.
        clear_sched();
        last_ack_off = -1; hdr_seen = 8'h00;
        run_txn(2'd3, 2'd0, 2'd1, 2, 1'b0, MAXOFF - 1);
        idle_cycles(1);
        check("pin_illegal_ack_cycle", 32'(last_ack_off), 32'd1);
        check("pin_illegal_err", 32'(last_err), 32'd1);
        check("pin_illegal_no_header", 32'(hdr_seen), 32'h00);

        // Zero length.
        clear_sched();
        last_ack_off = -1; hdr_seen = 8'h00;
        run_txn(2'd0, 2'd1, 2'd0, 0, 1'b0, MAXOFF - 1);
        idle_cycles(1);
        check("pin_zero_header", 32'(hdr_seen), 32'h10);
        check("pin_zero_ack_cycle", 32'(last_ack_off), 32'd5);

        // Back-to-back: next request held through ACK.
        clear_sched();
        sched[5] = 1'b1;
        nxt_src = 2'd2; nxt_dest = 2'd1; nxt_op = 2'd2; nxt_len = 1;
        run_txn(2'd0, 2'd2, 2'd1, 1, 1'b1, MAXOFF - 1);
        clear_sched();
        sched[6] = 1'b1;
        run_txn(nxt_src, nxt_dest, nxt_op, nxt_len, 1'b0, MAXOFF - 1);
        idle_cycles(1);

        // Short transfer: aborts on idle with the feature, otherwise stays busy.
        clear_sched();
        sched[5] = 1'b1; sched[6] = 1'b1;
        last_ack_off = -1;
        run_txn(2'd1, 2'd0, 2'd2, 5, 1'b0, 40);
`ifdef CTRL_TIMEOUT_EN
        idle_cycles(1);
        check("pin_timeout_ack_cycle", 32'(last_ack_off), 32'd15);
        check("pin_timeout_count", 32'(last_cnt), 32'd2);
        check("pin_timeout_err", 32'(last_err), 32'd1);
`else
        check("pin_no_timeout_busy", 32'(busy), 32'd1);
        mid_reset();
`endif

        // Reset mid-XFER after 2 of 4 bytes, then a clean transaction.
        clear_sched();
        sched[5] = 1'b1; sched[6] = 1'b1;
        run_txn(2'd2, 2'd1, 2'd1, 4, 1'b0, 7);
        mid_reset();
        clear_sched();
        for (int t = 5; t <= 8; t++) sched[t] = 1'b1;
        last_ack_off = -1;
        run_txn(2'd1, 2'd2, 2'd0, 4, 1'b0, MAXOFF - 1);
        idle_cycles(1);
        check("pin_after_reset_ack_cycle", 32'(last_ack_off), 32'd9);

        // Randomized traffic.
        nxt_src = 2'($urandom_range(0, 3)); nxt_dest = 2'($urandom_range(0, 3));
        nxt_op = 2'($urandom_range(0, 3)); nxt_len = $urandom_range(0, 6);
        for (int i = 0; i < 30; i++) begin
            s = nxt_src; d = nxt_dest; o = nxt_op; l = nxt_len;
            nxt_src = 2'($urandom_range(0, 3)); nxt_dest = 2'($urandom_range(0, 3));
            nxt_op = 2'($urandom_range(0, 3)); nxt_len = $urandom_range(0, 6);
            for (int t = 0; t < MAXOFF; t++)
                sched[t] = (t < 2) ? 1'b0 : (t >= 40) ? 1'b1 : bit'($urandom_range(0, 1));
            b2b = (i == 29) ? 1'b0 : bit'($urandom_range(0, 1));
            run_txn(s, d, o, l, b2b, MAXOFF - 1);
            if (!b2b) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
